uart_tx_arb: RTL and testbench

//  Shares the single UART transmitter (uart_top tx port) between two byte sources:
//  req0 = sequencer result stream (o_tx_data/o_tx_valid), req1 = board send-button path.

---
 rtl/uart_tx_arb_pkg.sv | 21 ++
 rtl/uart_tx_req_slot.sv | 55 +++++
 rtl/uart_tx_arb.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arb.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared state encodings, width defaults and the round-robin pick rule for the
// UART transmit arbiter.
package uart_tx_arb_pkg;

    localparam int unsigned ARB_DW      = 8;
    localparam int unsigned ARB_REG_W   = 2;
    localparam int unsigned ARB_BUSY_TO = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStb    = 2'd1,
        StWaitHi = 2'd2,
        StWaitLo = 2'd3
    } arb_state_e;

    // A lone requester wins; on a tie the requester not served last wins.
    function automatic logic rr_pick(input logic full0, input logic full1, input logic last);
        return (full0 && full1) ? ~last : full1;
    endfunction

endpackage

// File: rtl/uart_tx_req_slot.sv
// One-deep valid/ready holding register for a single byte source.
// Captures while empty; the arbiter empties it through i_clr.
module uart_tx_req_slot
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned DW    = ARB_DW,
    parameter int unsigned REG_W = ARB_REG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [DW-1:0]    i_data,
    input  logic [REG_W-1:0] i_reg,
    output logic             o_ready,
    input  logic             i_clr,
    output logic             o_full,
    output logic [DW-1:0]    o_data,
    output logic [REG_W-1:0] o_reg
);

    logic             full_q, full_d;
    logic [DW-1:0]    data_q, data_d;
    logic [REG_W-1:0] reg_q, reg_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        reg_d  = reg_q;
        if (i_clr) begin
            full_d = 1'b0;
        end else if (i_valid && !full_q) begin
            full_d = 1'b1;
            data_d = i_data;
            reg_d  = i_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            reg_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            reg_q  <= reg_d;
        end
    end

    assign o_ready = ~full_q;
    assign o_full  = full_q;
    assign o_data  = data_q;
    assign o_reg   = reg_q;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between two byte sources,
// with a busy-handshake timeout and a completed-byte counter.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned DW      = ARB_DW,
    parameter int unsigned REG_W   = ARB_REG_W,
    parameter int unsigned BUSY_TO = ARB_BUSY_TO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req0_valid,
    input  logic [DW-1:0]    i_req0_data,
    input  logic [REG_W-1:0] i_req0_reg,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [DW-1:0]    i_req1_data,
    input  logic [REG_W-1:0] i_req1_reg,
    output logic             o_req1_ready,
    output logic [DW-1:0]    o_tx_data,
    output logic [REG_W-1:0] o_tx_reg,
    output logic             o_tx_stb,
    input  logic             i_tx_busy,
    output logic             o_grant,
    output logic             o_busy,
    output logic [7:0]       o_sent_cnt,
    output logic             o_to_pulse
);

    localparam int unsigned CW = $clog2(BUSY_TO + 1);

    logic             full0, full1, clr0, clr1, win;
    logic [DW-1:0]    data0, data1;
    logic [REG_W-1:0] reg0, reg1;

    arb_state_e       state_q, state_d;
    logic [DW-1:0]    tx_data_q, tx_data_d;
    logic [REG_W-1:0] tx_reg_q, tx_reg_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             stb_q, stb_d;
    logic             to_q, to_d;
    logic [CW-1:0]    ctr_q, ctr_d;
    logic [7:0]       cnt_q, cnt_d;

    uart_tx_req_slot #(.DW(DW), .REG_W(REG_W)) u_slot0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_req0_valid),
        .i_data  (i_req0_data),
        .i_reg   (i_req0_reg),
        .o_ready (o_req0_ready),
        .i_clr   (clr0),
        .o_full  (full0),
        .o_data  (data0),
        .o_reg   (reg0)
    );

    uart_tx_req_slot #(.DW(DW), .REG_W(REG_W)) u_slot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_req1_valid),
        .i_data  (i_req1_data),
        .i_reg   (i_req1_reg),
        .o_ready (o_req1_ready),
        .i_clr   (clr1),
        .o_full  (full1),
        .o_data  (data1),
        .o_reg   (reg1)
    );

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_reg_d  = tx_reg_q;
        grant_d   = grant_q;
        last_d    = last_q;
        ctr_d     = ctr_q;
        cnt_d     = cnt_q;
        stb_d     = 1'b0;
        to_d      = 1'b0;
        clr0      = 1'b0;
        clr1      = 1'b0;
        win       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!i_tx_busy && (full0 || full1)) begin
                    win       = rr_pick(full0, full1, last_q);
                    tx_data_d = win ? data1 : data0;
                    tx_reg_d  = win ? reg1 : reg0;
                    grant_d   = win;
                    last_d    = win;
                    stb_d     = 1'b1;
                    state_d   = StStb;
                end
            end
            StStb: begin
                // Slot is released as the strobe goes out; its source sees ready next cycle.
                clr0    = ~grant_q;
                clr1    = grant_q;
                ctr_d   = '0;
                state_d = StWaitHi;
            end
            StWaitHi: begin
                if (i_tx_busy) begin
                    state_d = StWaitLo;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                    if (ctr_d == CW'(BUSY_TO - 1)) begin
                        to_d    = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StWaitLo: begin
                if (!i_tx_busy) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tx_data_q <= '0;
            tx_reg_q  <= '0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            stb_q     <= 1'b0;
            to_q      <= 1'b0;
            ctr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_reg_q  <= tx_reg_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            stb_q     <= stb_d;
            to_q      <= to_d;
            ctr_q     <= ctr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_reg   = tx_reg_q;
    assign o_tx_stb   = stb_q;
    assign o_grant    = grant_q;
    assign o_busy     = (state_q != StIdle);
    assign o_sent_cnt = cnt_q;
    assign o_to_pulse = to_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: a UART busy responder plus per-source byte queues that
// predict strobe order, grant, data and the completed-byte count.
module tb_uart_tx_arb;

    localparam int unsigned DW      = 8;
    localparam int unsigned REG_W   = 2;
    localparam int unsigned BUSY_TO = 16;
    localparam int unsigned RVW     = 6 + REG_W + DW + 8;
    localparam logic [RVW-1:0] RST_EXP = {6'b110000, {(REG_W + DW + 8){1'b0}}};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             r0_valid = 1'b0, r1_valid = 1'b0;
    logic [DW-1:0]    r0_data = '0, r1_data = '0;
    logic [REG_W-1:0] r0_reg = '0, r1_reg = '0;
    logic             ready0, ready1, tx_stb, tx_busy, grant, busy, to_pulse;
    logic [DW-1:0]    tx_data;
    logic [REG_W-1:0] tx_reg;
    logic [7:0]       sent_cnt;

    logic busy_auto, busy_force = 1'b0, auto_en = 1'b1, stb_prev = 1'b0, m_last = 1'b1;
    int   busy_len = 10, busy_left, cyc = 0, stb_total = 0;
    int   tests = 0, fails = 0, exp_cnt = 0;

    wire [RVW-1:0] rst_vec = {ready0, ready1, tx_stb, grant, busy, to_pulse,
                              tx_reg, tx_data, sent_cnt};

    uart_tx_arb #(.DW(DW), .REG_W(REG_W), .BUSY_TO(BUSY_TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req0_valid (r0_valid),
        .i_req0_data  (r0_data),
        .i_req0_reg   (r0_reg),
        .o_req0_ready (ready0),
        .i_req1_valid (r1_valid),
        .i_req1_data  (r1_data),
        .i_req1_reg   (r1_reg),
        .o_req1_ready (ready1),
        .o_tx_data    (tx_data),
        .o_tx_reg     (tx_reg),
        .o_tx_stb     (tx_stb),
        .i_tx_busy    (tx_busy),
        .o_grant      (grant),
        .o_busy       (busy),
        .o_sent_cnt   (sent_cnt),
        .o_to_pulse   (to_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign tx_busy = busy_auto | busy_force;

    // UART model: busy rises the cycle after a strobe and stays high busy_len cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_auto <= 1'b0;
            busy_left <= 0;
        end else if (auto_en && tx_stb) begin
            busy_auto <= 1'b1;
            busy_left <= busy_len;
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else begin
            busy_auto <= 1'b0;
            busy_left <= 0;
        end
    end

    always @(negedge clk) begin
        if (tx_stb) begin
            stb_total++;
            tests++;
            if (stb_prev) begin
                fails++;
                $display("FAIL stb_single: o_tx_stb high two cycles running at cycle %0d, required one", cyc);
            end
        end
        stb_prev = tx_stb;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic found;
        int   st;
        #2;
        tests++;
        if (rst_vec !== RST_EXP) begin
            fails++;
            $display("FAIL reset_initial: outputs %h, required %h", rst_vec, RST_EXP);
        end
        tick();
        rst_n = 1'b1;
        tick();
        busy_len = 10;
        r0_valid = 1'b1; r0_data = 8'h5C; r0_reg = 2'd1;
        tick();
        r0_valid = 1'b0;
        found = 1'b0;
        for (int w = 0; w < 8; w++) begin
            if (tx_stb) begin found = 1'b1; break; end
            tick();
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL reset_setup_stb: no strobe seen, required one");
        end
        tick();
        r0_valid = 1'b1; r0_data = 8'h3E; r0_reg = 2'd3;
        tick();
        r0_valid = 1'b0;
        tick();
        tick();
        tests++;
        if ({busy, tx_busy, ready0} !== 3'b110) begin
            fails++;
            $display("FAIL reset_pre: busy/uart_busy/ready0 = %b, required 110", {busy, tx_busy, ready0});
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (rst_vec !== RST_EXP) begin
            fails++;
            $display("FAIL reset_async: outputs %h, required %h", rst_vec, RST_EXP);
        end
        tick();
        rst_n = 1'b1;
        m_last = 1'b1;
        exp_cnt = 0;
        st = stb_total;
        repeat (30) tick();
        tests++;
        if (stb_total != st || sent_cnt !== 8'd0 || ready0 !== 1'b1) begin
            fails++;
            $display("FAIL reset_after: strobes %0d cnt %0d ready0 %b, required 0 0 1",
                     stb_total - st, sent_cnt, ready0);
        end
    endtask

    task automatic test_traffic(input string name, input int cycles, input int p0, input int p1,
                                input logic fixed_first, input int busy_max);
        logic [REG_W+DW-1:0] q0[$], q1[$];
        logic [REG_W+DW-1:0] exp_b;
        logic pend0, pend1, acc0, acc1, exp_g;
        int served;
        auto_en = 1'b1;
        busy_force = 1'b0;
        pend0 = 1'b0; pend1 = 1'b0; acc0 = 1'b0; acc1 = 1'b0; served = 0;
        for (int i = 0; i < cycles + 400; i++) begin
            if (acc0) begin q0.push_back({r0_reg, r0_data}); r0_valid = 1'b0; end
            if (acc1) begin q1.push_back({r1_reg, r1_data}); r1_valid = 1'b0; end
            if (tx_stb) begin
                tests++;
                if (!(pend0 || pend1)) begin
                    fails++;
                    $display("FAIL %s_stb: strobe at cycle %0d with nothing pending", name, cyc);
                end else begin
                    exp_g = (pend0 && pend1) ? ~m_last : pend1;
                    m_last = exp_g;
                    exp_b = exp_g ? q1.pop_front() : q0.pop_front();
                    if (grant !== exp_g || {tx_reg, tx_data} !== exp_b) begin
                        fails++;
                        $display("FAIL %s_order: grant %b byte %h at cycle %0d, required grant %b byte %h",
                                 name, grant, {tx_reg, tx_data}, cyc, exp_g, exp_b);
                    end
                    exp_cnt++;
                    served++;
                end
            end
            pend0 = (q0.size() > 0);
            pend1 = (q1.size() > 0);
            if (i < cycles) begin
                if (!r0_valid && $urandom_range(99, 0) < p0) begin
                    r0_valid = 1'b1;
                    r0_data = (fixed_first && i == 0) ? 8'h11 : DW'($urandom);
                    r0_reg = REG_W'($urandom);
                end
                if (!r1_valid && $urandom_range(99, 0) < p1) begin
                    r1_valid = 1'b1;
                    r1_data = (fixed_first && i == 0) ? 8'h22 : DW'($urandom);
                    r1_reg = REG_W'($urandom);
                end
            end else if (!r0_valid && !r1_valid && !pend0 && !pend1 && !busy && !tx_busy) begin
                break;
            end
            acc0 = r0_valid && ready0;
            acc1 = r1_valid && ready1;
            busy_len = $urandom_range(busy_max, 1);
            tick();
        end
        tests++;
        if (q0.size() != 0 || q1.size() != 0 || busy || served < 4) begin
            fails++;
            $display("FAIL %s_drain: left %0d/%0d bytes busy %b served %0d, required 0/0 0 >=4",
                     name, q0.size(), q1.size(), busy, served);
        end
        tests++;
        if (sent_cnt !== 8'(exp_cnt)) begin
            fails++;
            $display("FAIL %s_cnt: o_sent_cnt %0d, required %0d", name, sent_cnt, 8'(exp_cnt));
        end
    endtask

    task automatic test_single();
        busy_len = 10;
        auto_en = 1'b1;
        r0_valid = 1'b1; r0_data = 8'hA5; r0_reg = 2'd2;
        tick();
        r0_valid = 1'b0;
        tests++;
        if (ready0 !== 1'b0 || tx_stb !== 1'b0) begin
            fails++;
            $display("FAIL single_capture: ready0 %b stb %b, required 0 0", ready0, tx_stb);
        end
        tick();
        tests++;
        if (tx_stb !== 1'b1 || tx_data !== 8'hA5 || tx_reg !== 2'd2 || grant !== 1'b0) begin
            fails++;
            $display("FAIL single_stb: stb %b data %h reg %0d grant %b, required 1 a5 2 0",
                     tx_stb, tx_data, tx_reg, grant);
        end
        m_last = 1'b0;
        tick();
        tests++;
        if (tx_stb !== 1'b0 || ready0 !== 1'b1) begin
            fails++;
            $display("FAIL single_ready: stb %b ready0 %b, required 0 1", tx_stb, ready0);
        end
        repeat (3) tick();
        tests++;
        if (tx_data !== 8'hA5 || tx_reg !== 2'd2 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_hold: data %h reg %0d busy %b, required a5 2 1", tx_data, tx_reg, busy);
        end
        for (int w = 0; w < 40 && busy; w++) tick();
        exp_cnt++;
        tests++;
        if (busy !== 1'b0 || sent_cnt !== 8'(exp_cnt)) begin
            fails++;
            $display("FAIL single_cnt: busy %b cnt %0d, required 0 %0d", busy, sent_cnt, 8'(exp_cnt));
        end
    endtask

    task automatic test_busy_idle();
        int st;
        busy_len = 4;
        busy_force = 1'b1;
        tick();
        r1_valid = 1'b1; r1_data = 8'h7E; r1_reg = 2'd3;
        tick();
        r1_valid = 1'b0;
        st = stb_total;
        repeat (48) tick();
        tests++;
        if (stb_total != st || busy !== 1'b0 || ready1 !== 1'b0) begin
            fails++;
            $display("FAIL busyidle_hold: strobes %0d busy %b ready1 %b, required 0 0 0",
                     stb_total - st, busy, ready1);
        end
        busy_force = 1'b0;
        tick();
        tests++;
        if (tx_stb !== 1'b1 || grant !== 1'b1 || {tx_reg, tx_data} !== {2'd3, 8'h7E}) begin
            fails++;
            $display("FAIL busyidle_stb: stb %b grant %b byte %h, required 1 1 %h",
                     tx_stb, grant, {tx_reg, tx_data}, {2'd3, 8'h7E});
        end
        m_last = 1'b1;
        tick();
        for (int w = 0; w < 40 && busy; w++) tick();
        exp_cnt++;
        tests++;
        if (sent_cnt !== 8'(exp_cnt)) begin
            fails++;
            $display("FAIL busyidle_cnt: cnt %0d, required %0d", sent_cnt, 8'(exp_cnt));
        end
    endtask

    task automatic test_timeout();
        int early;
        auto_en = 1'b0;
        busy_len = 3;
        r0_valid = 1'b1; r0_data = 8'hC3; r0_reg = 2'd1;
        r1_valid = 1'b1; r1_data = 8'h3C; r1_reg = 2'd0;
        tick();
        r0_valid = 1'b0; r1_valid = 1'b0;
        tick();
        tests++;
        if (tx_stb !== 1'b1 || grant !== 1'b0 || tx_data !== 8'hC3) begin
            fails++;
            $display("FAIL timeout_first: stb %b grant %b data %h, required 1 0 c3", tx_stb, grant, tx_data);
        end
        m_last = 1'b0;
        early = 0;
        for (int k = 1; k < BUSY_TO; k++) begin
            tick();
            if (to_pulse !== 1'b0 || tx_stb !== 1'b0) early++;
        end
        tests++;
        if (early != 0) begin
            fails++;
            $display("FAIL timeout_early: %0d early pulse/strobe cycles, required 0", early);
        end
        tick();
        tests++;
        if (to_pulse !== 1'b1 || sent_cnt !== 8'(exp_cnt)) begin
            fails++;
            $display("FAIL timeout_pulse: pulse %b cnt %0d, required 1 %0d", to_pulse, sent_cnt, 8'(exp_cnt));
        end
        auto_en = 1'b1;
        tick();
        tests++;
        if (to_pulse !== 1'b0 || tx_stb !== 1'b1 || grant !== 1'b1 || tx_data !== 8'h3C) begin
            fails++;
            $display("FAIL timeout_next: pulse %b stb %b grant %b data %h, required 0 1 1 3c",
                     to_pulse, tx_stb, grant, tx_data);
        end
        m_last = 1'b1;
        tick();
        for (int w = 0; w < 40 && busy; w++) tick();
        exp_cnt++;
        tests++;
        if (sent_cnt !== 8'(exp_cnt)) begin
            fails++;
            $display("FAIL timeout_cnt: cnt %0d, required %0d", sent_cnt, 8'(exp_cnt));
        end
    endtask

    task automatic test_wrap();
        int n;
        logic hung;
        auto_en = 1'b1;
        busy_len = 1;
        n = 256 - (exp_cnt % 256);
        hung = 1'b0;
        for (int k = 0; k < n && !hung; k++) begin
            r0_valid = 1'b1; r0_data = DW'($urandom); r0_reg = REG_W'($urandom);
            tick();
            r0_valid = 1'b0;
            for (int w = 0; w < 6 && !tx_stb; w++) tick();
            if (!tx_stb) hung = 1'b1;
            tick();
            for (int w = 0; w < 30 && busy; w++) tick();
            if (busy) hung = 1'b1;
            exp_cnt++;
            if (exp_cnt % 256 == 255) begin
                tests++;
                if (sent_cnt !== 8'd255) begin
                    fails++;
                    $display("FAIL wrap_255: cnt %0d, required 255", sent_cnt);
                end
            end
        end
        tests++;
        if (hung || sent_cnt !== 8'd0) begin
            fails++;
            $display("FAIL wrap_zero: hung %b cnt %0d, required 0 0", hung, sent_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_traffic("contention", 60, 100, 100, 1'b1, 3);
        test_single();
        test_busy_idle();
        test_timeout();
        test_traffic("random", 800, 35, 45, 1'b0, 8);
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
